// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU request/response bundle: operands and opcode in, handshake and results out.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             divz;

  modport master (
    output start, srca, srcb, alucontrol,
    input  ready, busy, done, result, hi, zero, divz
  );

  modport slave (
    input  start, srca, srcb, alucontrol,
    output ready, busy, done, result, hi, zero, divz
  );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle MIPS ALU: registered logic/arith ops plus iterative MULTU (shift-add) and DIVU (restoring).
// Define ALU_MULDIV_EN to build the multiply/divide states and datapath; otherwise 0100/0101 act as undefined ops.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b0101;
  localparam int         CNT_W    = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MUL = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t           state, state_next;
  logic             ready, busy, done, is_iter;
  logic [WIDTH-1:0] alu_res, result_r, hi_r;
  logic             zero_r, divz_r;

  always_comb begin
    alu_res = '0;
    case (bus.alucontrol)
      OP_AND:  alu_res = bus.srca & bus.srcb;
      OP_OR:   alu_res = bus.srca | bus.srcb;
      OP_ADD:  alu_res = bus.srca + bus.srcb;
      OP_XOR:  alu_res = bus.srca ^ bus.srcb;
      OP_SUB:  alu_res = bus.srca - bus.srcb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.srca) < $signed(bus.srcb))};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] work_hi, work_lo, opb;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_diff, div_rem_n, div_quo_n;
  logic             div_ge;

  assign is_iter = (bus.alucontrol == OP_MULTU) || (bus.alucontrol == OP_DIVU);

  // work_hi/work_lo hold {partial product, multiplier} or {remainder, dividend}; opb is the fixed operand.
  // Divisor 0 never restores, so the quotient fills with ones and the remainder collects srca unchanged.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], work_lo[WIDTH-1:1]};
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_diff  = div_shift[WIDTH-1:0] - opb;
    div_rem_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo_n = {work_lo[WIDTH-2:0], div_ge};
  end
`else
  assign is_iter = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
`ifdef ALU_MULDIV_EN
          if (bus.alucontrol == OP_MULTU)     state_next = S_MUL;
          else if (bus.alucontrol == OP_DIVU) state_next = S_DIV;
          else                                state_next = S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (cnt == '0) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r <= '0;
      hi_r     <= '0;
      zero_r   <= 1'b0;
      divz_r   <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      opb      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !is_iter) begin
            result_r <= alu_res;
            hi_r     <= '0;
            zero_r   <= (alu_res == '0);
            divz_r   <= 1'b0;
          end
`ifdef ALU_MULDIV_EN
          if (bus.start && is_iter) begin
            work_hi <= '0;
            work_lo <= bus.srca;
            opb     <= bus.srcb;
            cnt     <= CNT_W'(WIDTH - 1);
          end
`endif
        end
`ifdef ALU_MULDIV_EN
        // The last iteration writes the visible outputs directly so done follows on the next cycle.
        S_MUL: begin
          work_hi <= mul_hi_n;
          work_lo <= mul_lo_n;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else begin
            result_r <= mul_lo_n;
            hi_r     <= mul_hi_n;
            zero_r   <= (mul_lo_n == '0);
            divz_r   <= 1'b0;
          end
        end
        S_DIV: begin
          work_hi <= div_rem_n;
          work_lo <= div_quo_n;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else begin
            result_r <= div_quo_n;
            hi_r     <= div_rem_n;
            zero_r   <= (div_quo_n == '0);
            divz_r   <= (opb == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.ready  = ready;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_r;
  assign bus.hi     = hi_r;
  assign bus.zero   = zero_r;
  assign bus.divz   = divz_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed vector table, hand-built multi-cycle sequences, and randomized ops vs. a reference model.
module tb_alu_muldiv;
  localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int LAT_MD = MD_EN ? WIDTH + 1 : 1;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        divz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(WIDTH)) bus ();
  alu_muldiv #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic [31:0] hi,
                              input logic zero, input logic divz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.zero = zero; v.divz = divz; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain arithmetic on the operands, 64-bit wide product, native / and %.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t        v;
    logic [63:0] p;
    v = mk(op, a, b, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    case (op)
      4'b0000: v.res = a & b;
      4'b0001: v.res = a | b;
      4'b0010: v.res = a + b;
      4'b0011: v.res = a ^ b;
      4'b0110: v.res = a - b;
      4'b0111: v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: if (MD_EN) begin
        p = {32'd0, a} * {32'd0, b};
        v.res = p[31:0];
        v.hi  = p[63:32];
        v.lat = WIDTH + 1;
      end
      4'b0101: if (MD_EN) begin
        if (b == 0) begin
          v.res = 32'hFFFF_FFFF; v.hi = a; v.divz = 1'b1;
        end else begin
          v.res = a / b; v.hi = a % b;
        end
        v.lat = WIDTH + 1;
      end
      default: ;
    endcase
    v.zero = (v.res == 0);
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {63'd0, bus.ready}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit busy_seen;
    wait_ready(tag);
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = v.op; bus.srca = v.a; bus.srcb = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.srca = $urandom; bus.srcb = $urandom; bus.alucontrol = 4'($urandom);
    lat = 1;
    busy_seen = 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin
      busy_seen = busy_seen | (bus.busy === 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},    64'(lat), 64'(v.lat));
    chk({tag, "_result"}, {32'd0, bus.result}, {32'd0, v.res});
    chk({tag, "_hi"},     {32'd0, bus.hi}, {32'd0, v.hi});
    chk({tag, "_zero"},   {63'd0, bus.zero}, {63'd0, v.zero});
    chk({tag, "_divz"},   {63'd0, bus.divz}, {63'd0, v.divz});
    chk({tag, "_busy"},   {63'd0, busy_seen}, {63'd0, (v.lat > 1)});
    @(posedge clk); #1;
    chk({tag, "_done1"},  {63'd0, bus.done}, 64'd0);
    chk({tag, "_idle"},   {63'd0, bus.ready}, 64'd1);
    chk({tag, "_hold"},   {32'd0, bus.result}, {32'd0, v.res});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  {63'd0, bus.ready}, 64'd1);
    chk({tag, "_busy"},   {63'd0, bus.busy}, 64'd0);
    chk({tag, "_done"},   {63'd0, bus.done}, 64'd0);
    chk({tag, "_result"}, {32'd0, bus.result}, 64'd0);
    chk({tag, "_hi"},     {32'd0, bus.hi}, 64'd0);
    chk({tag, "_zero"},   {63'd0, bus.zero}, 64'd0);
    chk({tag, "_divz"},   {63'd0, bus.divz}, 64'd0);
  endtask

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    vec_t v;
    logic [3:0] ops[8];
    int lat;

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b0100, 4'b0101};
    tbl[0]  = mk(4'b0000, 32'd8, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[1]  = mk(4'b0001, 32'd8, 32'd1, 32'd9, 32'd0, 1'b0, 1'b0, 1);
    tbl[2]  = mk(4'b0010, 32'd8, 32'd1, 32'd9, 32'd0, 1'b0, 1'b0, 1);
    tbl[3]  = mk(4'b0110, 32'd8, 32'd1, 32'd7, 32'd0, 1'b0, 1'b0, 1);
    tbl[4]  = mk(4'b0111, 32'd8, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[5]  = mk(4'b0111, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    tbl[6]  = mk(4'b0110, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1);
    tbl[7]  = mk(4'b0110, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[8]  = mk(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 32'd0, 1'b0, 1'b0, 1);
    tbl[9]  = mk(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[10] = mk(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[11] = mk(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 1);
    tbl[12] = mk(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_EN ? 32'd1 : 32'd0,
                 MD_EN ? 32'hFFFF_FFFE : 32'd0, !MD_EN, 1'b0, LAT_MD);
    tbl[13] = mk(4'b0101, 32'd100, 32'd7, MD_EN ? 32'd14 : 32'd0, MD_EN ? 32'd2 : 32'd0,
                 !MD_EN, 1'b0, LAT_MD);
    tbl[14] = mk(4'b0101, 32'd5, 32'd0, MD_EN ? 32'hFFFF_FFFF : 32'd0, MD_EN ? 32'd5 : 32'd0,
                 !MD_EN, MD_EN, LAT_MD);
    tbl[15] = mk(4'b0100, 32'd3, 32'd4, MD_EN ? 32'd12 : 32'd0, 32'd0, !MD_EN, 1'b0, LAT_MD);

    bus.start = 1'b0; bus.srca = '0; bus.srcb = '0; bus.alucontrol = '0;
    reset = 1'b1;
    #2;
    chk_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a MULTU is iterating.
    run_vec(mk(4'b0010, 32'd8, 32'd1, 32'd9, 32'd0, 1'b0, 1'b0, 1), "pre_rst");
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = 4'b0100; bus.srca = 32'hFFFF_FFFF; bus.srcb = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, bus.busy}, {63'd0, MD_EN});
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    @(posedge clk); #1;
    chk_reset_vals("rst_edge");
    @(negedge clk);
    reset = 1'b0;
    run_vec(mk(4'b0010, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1), "post_rst");

    // start held high through a MULTU, operands switched to ADD right after accept.
    wait_ready("hold");
    @(negedge clk);
    bus.start = 1'b1; bus.alucontrol = 4'b0100; bus.srca = 32'd7; bus.srcb = 32'd9;
    @(posedge clk); #1;
    bus.alucontrol = 4'b0010; bus.srca = 32'd1; bus.srcb = 32'd2;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 64'(lat), 64'(LAT_MD));
    chk("hold_mul", {32'd0, bus.result}, MD_EN ? 64'd63 : 64'd0);
    @(posedge clk); #1;
    chk("hold_ready", {63'd0, bus.ready}, 64'd1);
    chk("hold_nodone", {63'd0, bus.done}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("hold_done2", {63'd0, bus.done}, 64'd1);
    chk("hold_add", {32'd0, bus.result}, 64'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = 32'($urandom);
      endcase
      v = model(op, a, b);
      run_vec(v, $sformatf("rnd%0d_op%0h", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
